// File: rtl/uart_cfg_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_cfg_core (with helper uart_cfg_fifo)
// Purpose : Full-duplex UART core with a runtime frame format (5-8 data bits,
//           none/even/odd parity, 1 or 2 stop bits), a programmable tick
//           divisor, FWFT TX/RX FIFOs and sticky RX error flags.
// Ports   : clk, rst_n (async active-low)
//           i_cfg_div/i_cfg_dbits/i_cfg_parity/i_cfg_stop2 : frame format
//           i_tx_wen/i_tx_wdata -> TX FIFO -> o_tx (idle high)
//           o_tx_full/o_tx_empty/o_tx_busy/o_tx_done       : TX status
//           i_rx -> sync -> RX FSM -> RX FIFO -> o_rx_rdata (i_rx_ren pops)
//           o_rx_full/o_rx_empty/o_rx_done                 : RX status
//           o_rx_parity_err/o_rx_frame_err/o_rx_overrun    : sticky, i_err_clr
// Option  : `define UART_LOOPBACK_EN builds the loopback mux driven by
//           i_lpbk_en; otherwise i_lpbk_en is ignored.
// Revision: 1.0 - initial release
// ============================================================================

module uart_cfg_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_ren,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic             r_full, r_empty, w_do_wr, w_do_rd;

    // A write on a full FIFO is accepted only when a read frees a slot in
    // the same cycle.
    assign w_do_rd    = i_ren && !r_empty;
    assign w_do_wr    = i_wen && (!r_full || w_do_rd);
    assign w_wptr_nxt = w_do_wr ? r_wptr + c_PTR_ONE : r_wptr;
    assign w_rptr_nxt = w_do_rd ? r_rptr + c_PTR_ONE : r_rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    // Storage is not reset; gating on empty gives a clean zero head.
    assign o_rdata = r_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;
endmodule

module uart_cfg_core #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic [1:0]       i_cfg_dbits,
    input  logic [1:0]       i_cfg_parity,
    input  logic             i_cfg_stop2,
    input  logic             i_lpbk_en,
    input  logic             i_tx_wen,
    input  logic [7:0]       i_tx_wdata,
    output logic             o_tx,
    output logic             o_tx_full,
    output logic             o_tx_empty,
    output logic             o_tx_busy,
    output logic             o_tx_done,
    input  logic             i_rx,
    input  logic             i_rx_ren,
    output logic [7:0]       o_rx_rdata,
    output logic             o_rx_full,
    output logic             o_rx_empty,
    output logic             o_rx_done,
    output logic             o_rx_parity_err,
    output logic             o_rx_frame_err,
    output logic             o_rx_overrun,
    input  logic             i_err_clr
);
    localparam int                OS_W       = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   c_OS_ONE   = OS_W'(1);
    localparam logic [OS_W-1:0]   c_OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   c_OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0]  c_DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // Tick generator: a divisor of 0 behaves like 1 (tick every clock).
    // The >= compare lets a shrinking divisor take effect without wrap.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_tick_cnt, w_div_m1;
    logic             w_tick;

    assign w_div_m1 = (i_cfg_div == '0) ? '0 : i_cfg_div - c_DIV_ONE;
    assign w_tick   = (r_tick_cnt >= w_div_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_DIV_ONE;
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t       r_tx_state, w_tx_state_nxt;
    logic [OS_W-1:0] r_tx_os;
    logic [2:0]      r_tx_bit, r_tx_last_bit;
    logic [7:0]      r_tx_shift, w_txf_rdata, w_tx_mask, w_tx_masked;
    logic            r_tx_par_en, r_tx_par_bit, r_tx_stop2, r_tx_stop_cnt;
    logic            r_tx_done, w_tx_pop, w_tx_done, w_tx_bit_end;
    logic            w_txf_empty, w_tx_line;

    uart_cfg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wen   (i_tx_wen),
        .i_wdata (i_tx_wdata),
        .i_ren   (w_tx_pop),
        .o_rdata (w_txf_rdata),
        .o_full  (o_tx_full),
        .o_empty (w_txf_empty)
    );

    // Bits above the configured width are forced to zero before sending.
    assign w_tx_mask    = 8'hFF >> (2'd3 - i_cfg_dbits);
    assign w_tx_masked  = w_txf_rdata & w_tx_mask;
    assign w_tx_bit_end = w_tick && (r_tx_os == c_OS_LAST);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_pop       = 1'b0;
        w_tx_done      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_tick && !w_txf_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) w_tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (w_tx_bit_end && (r_tx_bit == r_tx_last_bit)) begin
                    w_tx_state_nxt = r_tx_par_en ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: begin
                if (w_tx_bit_end) w_tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (w_tx_bit_end && (!r_tx_stop2 || r_tx_stop_cnt)) begin
                    w_tx_done = 1'b1;
                    // Chain straight into the next start bit: no idle gap.
                    if (!w_txf_empty) begin
                        w_tx_pop       = 1'b1;
                        w_tx_state_nxt = TX_START;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state    <= TX_IDLE;
            r_tx_os       <= '0;
            r_tx_bit      <= 3'd0;
            r_tx_last_bit <= 3'd7;
            r_tx_shift    <= 8'h00;
            r_tx_par_en   <= 1'b0;
            r_tx_par_bit  <= 1'b0;
            r_tx_stop2    <= 1'b0;
            r_tx_stop_cnt <= 1'b0;
            r_tx_done     <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_done  <= w_tx_done;
            if (w_tx_pop) begin
                // Frame format is captured here and held for the whole frame.
                r_tx_os       <= '0;
                r_tx_bit      <= 3'd0;
                r_tx_last_bit <= {1'b1, i_cfg_dbits};
                r_tx_shift    <= w_tx_masked;
                r_tx_par_en   <= (i_cfg_parity == 2'b01) || (i_cfg_parity == 2'b10);
                r_tx_par_bit  <= (^w_tx_masked) ^ (i_cfg_parity == 2'b10);
                r_tx_stop2    <= i_cfg_stop2;
                r_tx_stop_cnt <= 1'b0;
            end else if (r_tx_state == TX_IDLE) begin
                r_tx_os <= '0;
            end else if (w_tick) begin
                r_tx_os <= w_tx_bit_end ? '0 : r_tx_os + c_OS_ONE;
                if (w_tx_bit_end && (r_tx_state == TX_DATA)) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
                if (w_tx_bit_end && (r_tx_state == TX_STOP)) begin
                    r_tx_stop_cnt <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_tx_line = 1'b1;
        case (r_tx_state)
            TX_START:  w_tx_line = 1'b0;
            TX_DATA:   w_tx_line = r_tx_shift[0];
            TX_PARITY: w_tx_line = r_tx_par_bit;
            default:   w_tx_line = 1'b1;
        endcase
    end

    assign o_tx_empty = w_txf_empty;
    assign o_tx_busy  = (r_tx_state != TX_IDLE);
    assign o_tx_done  = r_tx_done;

    // ------------------------------------------------------------------
    // Loopback selection
    // ------------------------------------------------------------------
    logic w_rx_pin;
`ifdef UART_LOOPBACK_EN
    assign o_tx     = i_lpbk_en ? 1'b1 : w_tx_line;
    assign w_rx_pin = i_lpbk_en ? w_tx_line : i_rx;
`else
    logic w_unused_lpbk;
    assign w_unused_lpbk = i_lpbk_en;
    assign o_tx          = w_tx_line;
    assign w_rx_pin      = i_rx;
`endif

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    rx_state_t       r_rx_state, w_rx_state_nxt;
    logic [OS_W-1:0] r_rx_os;
    logic [2:0]      r_rx_bit, r_rx_last_bit;
    logic [7:0]      r_rx_data;
    logic            r_rx_meta, r_rx_sync, r_rx_armed;
    logic            r_rx_par_en, r_rx_par_odd, r_rx_perr_pend, r_rx_done;
    logic            r_perr, r_ferr, r_ovr;
    logic            w_rx_sample, w_rx_start, w_rx_push;
    logic            w_rx_ferr_set, w_rx_perr_set, w_rx_ovr_set, w_rxf_full;

    uart_cfg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wen   (w_rx_push),
        .i_wdata (r_rx_data),
        .i_ren   (i_rx_ren),
        .o_rdata (o_rx_rdata),
        .o_full  (w_rxf_full),
        .o_empty (o_rx_empty)
    );

    assign w_rx_sample  = w_tick && (r_rx_os == c_OS_LAST);
    // A full FIFO still accepts the byte when the host pops in this cycle.
    assign w_rx_ovr_set = w_rx_push && w_rxf_full && !i_rx_ren;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_start     = 1'b0;
        w_rx_push      = 1'b0;
        w_rx_ferr_set  = 1'b0;
        w_rx_perr_set  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_tick && r_rx_armed && !r_rx_sync) begin
                    w_rx_start     = 1'b1;
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // Mid-start re-check: a high line here is a glitch.
                if (w_tick && (r_rx_os == c_OS_HALF)) begin
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_sample && (r_rx_bit == r_rx_last_bit)) begin
                    w_rx_state_nxt = r_rx_par_en ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (w_rx_sample) w_rx_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (w_rx_sample) begin
                    w_rx_push      = 1'b1;
                    w_rx_ferr_set  = !r_rx_sync;
                    w_rx_perr_set  = r_rx_perr_pend;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta      <= 1'b1;
            r_rx_sync      <= 1'b1;
            r_rx_state     <= RX_IDLE;
            r_rx_armed     <= 1'b0;
            r_rx_os        <= '0;
            r_rx_bit       <= 3'd0;
            r_rx_last_bit  <= 3'd7;
            r_rx_data      <= 8'h00;
            r_rx_par_en    <= 1'b0;
            r_rx_par_odd   <= 1'b0;
            r_rx_perr_pend <= 1'b0;
            r_rx_done      <= 1'b0;
        end else begin
            r_rx_meta  <= w_rx_pin;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state_nxt;
            r_rx_done  <= w_rx_push;
            // Re-arm only after a high line so a stuck-low input cannot
            // generate a stream of frames.
            if (w_rx_start) begin
                r_rx_armed <= 1'b0;
            end else if ((r_rx_state == RX_IDLE) && r_rx_sync) begin
                r_rx_armed <= 1'b1;
            end
            if (w_rx_start) begin
                r_rx_os        <= '0;
                r_rx_bit       <= 3'd0;
                r_rx_last_bit  <= {1'b1, i_cfg_dbits};
                r_rx_data      <= 8'h00;
                r_rx_par_en    <= (i_cfg_parity == 2'b01) || (i_cfg_parity == 2'b10);
                r_rx_par_odd   <= (i_cfg_parity == 2'b10);
                r_rx_perr_pend <= 1'b0;
            end else if (r_rx_state == RX_IDLE) begin
                r_rx_os <= '0;
            end else if (w_tick) begin
                if ((r_rx_state == RX_START) && (r_rx_os == c_OS_HALF)) begin
                    r_rx_os <= '0;
                end else begin
                    r_rx_os <= w_rx_sample ? '0 : r_rx_os + c_OS_ONE;
                end
                if (w_rx_sample && (r_rx_state == RX_DATA)) begin
                    r_rx_data[r_rx_bit] <= r_rx_sync;
                    r_rx_bit            <= r_rx_bit + 3'd1;
                end
                if (w_rx_sample && (r_rx_state == RX_PARITY)) begin
                    r_rx_perr_pend <= (r_rx_sync != ((^r_rx_data) ^ r_rx_par_odd));
                end
            end
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_perr <= w_rx_perr_set | (r_perr & ~i_err_clr);
            r_ferr <= w_rx_ferr_set | (r_ferr & ~i_err_clr);
            r_ovr  <= w_rx_ovr_set  | (r_ovr  & ~i_err_clr);
        end
    end

    assign o_rx_full       = w_rxf_full;
    assign o_rx_done       = r_rx_done;
    assign o_rx_parity_err = r_perr;
    assign o_rx_frame_err  = r_ferr;
    assign o_rx_overrun    = r_ovr;
endmodule

`default_nettype wire

// File: tb/tb_uart_cfg_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_cfg_core
// Purpose : Directed self-checking bench for uart_cfg_core (div=4, 64 clks
//           per bit). Covers reset, TX bit timing, loopback 7E2, parity
//           error and clear, FIFO full/overrun, false start, reset mid-frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_cfg_core;
    localparam int c_BIT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_dbits, cfg_parity;
    logic        cfg_stop2, lpbk_en, tx_wen, rx_ren, err_clr;
    logic [7:0]  tx_wdata, rx_rdata;
    logic        tx, tx_full, tx_empty, tx_busy, tx_done;
    logic        rx_full, rx_empty, rx_done, perr, ferr, ovr;
    logic        r_rx_drv, r_wire, w_rx;

    int n_vec = 0;
    int n_err = 0;
    int n_rxd = 0;

    assign w_rx = r_wire ? tx : r_rx_drv;

    uart_cfg_core #(.DIV_W(16), .OVERSAMPLE(16), .FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_cfg_div       (cfg_div),
        .i_cfg_dbits     (cfg_dbits),
        .i_cfg_parity    (cfg_parity),
        .i_cfg_stop2     (cfg_stop2),
        .i_lpbk_en       (lpbk_en),
        .i_tx_wen        (tx_wen),
        .i_tx_wdata      (tx_wdata),
        .o_tx            (tx),
        .o_tx_full       (tx_full),
        .o_tx_empty      (tx_empty),
        .o_tx_busy       (tx_busy),
        .o_tx_done       (tx_done),
        .i_rx            (w_rx),
        .i_rx_ren        (rx_ren),
        .o_rx_rdata      (rx_rdata),
        .o_rx_full       (rx_full),
        .o_rx_empty      (rx_empty),
        .o_rx_done       (rx_done),
        .o_rx_parity_err (perr),
        .o_rx_frame_err  (ferr),
        .o_rx_overrun    (ovr),
        .i_err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_done) n_rxd <= n_rxd + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_wen   = 1'b1;
        tx_wdata = d;
        @(negedge clk);
        tx_wen   = 1'b0;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        check_val(tag, 32'(rx_rdata), 32'(exp));
        rx_ren = 1'b1;
        @(negedge clk);
        rx_ren = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_tx_fall(output time t_fall);
        int n = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("tx_start_seen", 32'(tx == 1'b0), 32'd1);
        t_fall = $time;
    endtask

    task automatic wait_tx_done(output time t_done);
        int n = 0;
        while (tx_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("tx_done_seen", 32'(tx_done), 32'd1);
        t_done = $time;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits,
                              input logic par_en, input logic par_val, input int nstop);
        r_rx_drv = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            r_rx_drv = d[i];
            repeat (c_BIT) @(negedge clk);
        end
        if (par_en) begin
            r_rx_drv = par_val;
            repeat (c_BIT) @(negedge clk);
        end
        r_rx_drv = 1'b1;
        repeat (c_BIT * nstop) @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        time t0, t1;
        int  n0;

        rst_n = 1'b0; cfg_div = 16'd4; cfg_dbits = 2'b11; cfg_parity = 2'b00;
        cfg_stop2 = 1'b0; lpbk_en = 1'b0; tx_wen = 1'b0; tx_wdata = 8'h00;
        rx_ren = 1'b0; err_clr = 1'b0; r_rx_drv = 1'b1; r_wire = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_tx", 32'(tx), 32'd1);
        check_val("rst_tx_empty", 32'(tx_empty), 32'd1);
        check_val("rst_rx_empty", 32'(rx_empty), 32'd1);
        check_val("rst_fulls", 32'({tx_full, rx_full}), 32'd0);
        check_val("rst_busy_done", 32'({tx_busy, tx_done, rx_done}), 32'd0);
        check_val("rst_errs", 32'({perr, ferr, ovr}), 32'd0);
        check_val("rst_rdata", 32'(rx_rdata), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // T1: 8N1 0xA5, bit timing and tx_done position
        v = 8'hA5;
        push_tx(v);
        check_val("t1_tx_empty_after_push", 32'(tx_empty), 32'd0);
        wait_tx_fall(t0);
        repeat (c_BIT / 2) @(negedge clk);
        check_val("t1_start", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (c_BIT) @(negedge clk);
            check_val($sformatf("t1_bit%0d", i), 32'(tx), 32'(v[i]));
        end
        repeat (c_BIT) @(negedge clk);
        check_val("t1_stop", 32'(tx), 32'd1);
        wait_tx_done(t1);
        check_val("t1_done_clks", 32'((t1 - t0) / 10), 32'd640);
        check_val("t1_tx_empty", 32'(tx_empty), 32'd1);
        check_val("t1_busy", 32'(tx_busy), 32'd0);

        // T2: loopback wire, 7E2 0x55 -> parity 0, two stop bits
        r_wire = 1'b1; cfg_dbits = 2'b10; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        n0 = n_rxd;
        v = 8'h55;
        push_tx(v);
        wait_tx_fall(t0);
        repeat (c_BIT / 2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            repeat (c_BIT) @(negedge clk);
            check_val($sformatf("t2_bit%0d", i), 32'(tx), 32'(v[i]));
        end
        repeat (c_BIT) @(negedge clk);
        check_val("t2_parity", 32'(tx), 32'd0);
        repeat (c_BIT) @(negedge clk);
        check_val("t2_stop1", 32'(tx), 32'd1);
        repeat (c_BIT) @(negedge clk);
        check_val("t2_stop2", 32'(tx), 32'd1);
        wait_tx_done(t1);
        check_val("t2_done_clks", 32'((t1 - t0) / 10), 32'd704);
        check_val("t2_rx_done_cnt", 32'(n_rxd - n0), 32'd1);
        check_val("t2_errs", 32'({perr, ferr, ovr}), 32'd0);
        pop_rx("t2_rdata", 8'h55);
        check_val("t2_rx_empty", 32'(rx_empty), 32'd1);
        r_wire = 1'b0;
        repeat (c_BIT) @(negedge clk);

        // T3: 8O1 0x3C sent with even parity bit (0) -> parity error
        cfg_dbits = 2'b11; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
        n0 = n_rxd;
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1);
        check_val("t3_rx_done_cnt", 32'(n_rxd - n0), 32'd1);
        check_val("t3_perr", 32'(perr), 32'd1);
        check_val("t3_ferr_ovr", 32'({ferr, ovr}), 32'd0);
        check_val("t3_rdata", 32'(rx_rdata), 32'h3C);
        pulse_clr();
        check_val("t3_perr_cleared", 32'(perr), 32'd0);
        pop_rx("t3_pop", 8'h3C);

        // T4: nine frames, no pops -> full after 8, overrun after 9
        cfg_parity = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 8, 1'b0, 1'b0, 1);
            if (i == 7) check_val("t4_not_full_7", 32'(rx_full), 32'd0);
            if (i == 8) check_val("t4_full_ovr_8", 32'({rx_full, ovr}), 32'b10);
            if (i == 9) check_val("t4_full_ovr_9", 32'({rx_full, ovr}), 32'b11);
        end
        for (int i = 1; i <= 8; i++) begin
            pop_rx($sformatf("t4_pop%0d", i), 8'(i));
        end
        check_val("t4_rx_empty", 32'(rx_empty), 32'd1);
        pulse_clr();
        check_val("t4_ovr_cleared", 32'(ovr), 32'd0);

        // T5: 16-clk low glitch is a false start; next 0x81 is clean
        n0 = n_rxd;
        r_rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        r_rx_drv = 1'b1;
        repeat (3 * c_BIT) @(negedge clk);
        check_val("t5_no_done", 32'(n_rxd - n0), 32'd0);
        check_val("t5_no_flags", 32'({perr, ferr, ovr}), 32'd0);
        check_val("t5_rx_empty", 32'(rx_empty), 32'd1);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1);
        check_val("t5_done", 32'(n_rxd - n0), 32'd1);
        check_val("t5_flags", 32'({perr, ferr, ovr}), 32'd0);
        pop_rx("t5_rdata", 8'h81);

        // T6: reset asserted during data bit 3 of a TX frame
        push_tx(8'h00);
        push_tx(8'h00);
        wait_tx_fall(t0);
        repeat (c_BIT / 2 + 4 * c_BIT) @(negedge clk);
        check_val("t6_pre_tx", 32'(tx), 32'd0);
        check_val("t6_pre_busy_empty", 32'({tx_busy, tx_empty}), 32'b10);
        rst_n = 1'b0;
        #1;
        check_val("t6_tx_async", 32'(tx), 32'd1);
        check_val("t6_busy", 32'(tx_busy), 32'd0);
        check_val("t6_tx_empty", 32'(tx_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("t6_tx_idle", 32'(tx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
